// File: rtl/mac_ahb_master_pkg.sv
// Shared AHB-Lite encodings and MAC register map used by the master, the MAC slave and the benches.
package mac_ahb_master_pkg;

    typedef enum logic [1:0] {
        TransIdle   = 2'b00,
        TransBusy   = 2'b01,
        TransNonseq = 2'b10,
        TransSeq    = 2'b11
    } htrans_e;

    localparam logic [2:0]  HSIZE_WORD = 3'b010;

    localparam logic [31:0] MAC_OFS_A = 32'h0000_0000;
    localparam logic [31:0] MAC_OFS_B = 32'h0000_0004;
    localparam logic [31:0] MAC_OFS_R = 32'h0000_0008;

endpackage

// File: rtl/mac_ahb_master.sv
// AHB-Lite master that streams operand pairs into the MAC register block, then reads back
// the accumulator. Single non-overlapped transfers only; ERROR responses abort the job.
module mac_ahb_master
    import mac_ahb_master_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        hclk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_len,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic        res_err,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp
);

    typedef enum logic [3:0] {
        StIdle,
        StWaitOp,
        StAAddr,
        StAData,
        StBAddr,
        StBData,
        StRAddr,
        StRData,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] res_data_q, res_data_d;
    logic        res_err_q, res_err_d;

    always_ff @(posedge hclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    cnt_d     = cmd_len;
                    res_err_d = 1'b0;
                    state_d   = (cmd_len != 8'd0) ? StWaitOp : StRAddr;
                end
            end
            StWaitOp: begin
                if (op_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    state_d = StAAddr;
                end
            end
            StAAddr: if (hready) state_d = StAData;
            StAData: begin
                if (hready) begin
                    if (hresp) begin
                        res_err_d = 1'b1;
                        state_d   = StDone;
                    end else begin
                        state_d   = StBAddr;
                    end
                end
            end
            StBAddr: if (hready) state_d = StBData;
            StBData: begin
                if (hready) begin
                    if (hresp) begin
                        res_err_d = 1'b1;
                        state_d   = StDone;
                    end else begin
                        cnt_d   = cnt_q - 8'd1;
                        state_d = (cnt_d != 8'd0) ? StWaitOp : StRAddr;
                    end
                end
            end
            StRAddr: if (hready) state_d = StRData;
            StRData: begin
                if (hready) begin
                    // An errored read leaves the previous result visible.
                    if (hresp) begin
                        res_err_d  = 1'b1;
                    end else begin
                        res_data_d = hrdata;
                    end
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        op_ready  = 1'b0;
        res_valid = 1'b0;
        htrans    = TransIdle;
        haddr     = '0;
        hwrite    = 1'b0;
        hwdata    = '0;
        unique case (state_q)
            StIdle:   cmd_ready = 1'b1;
            StWaitOp: op_ready  = 1'b1;
            StAAddr: begin
                htrans = TransNonseq;
                haddr  = BASE_ADDR + MAC_OFS_A;
                hwrite = 1'b1;
            end
            StAData:  hwdata = a_q;
            StBAddr: begin
                htrans = TransNonseq;
                haddr  = BASE_ADDR + MAC_OFS_B;
                hwrite = 1'b1;
            end
            StBData:  hwdata = b_q;
            StRAddr: begin
                htrans = TransNonseq;
                haddr  = BASE_ADDR + MAC_OFS_R;
            end
            StRData:  ;
            StDone:   res_valid = 1'b1;
            default:  ;
        endcase
    end

    assign hsize    = HSIZE_WORD;
    assign res_data = res_data_q;
    assign res_err  = res_err_q;

endmodule

// File: tb/tb_mac_ahb_master.sv
// Scoreboard bench for mac_ahb_master with an AHB MAC slave stub (stalls and ERROR injection).
module tb_mac_ahb_master;
    import mac_ahb_master_pkg::*;

    localparam logic [31:0] BASE = 32'h4000_1000;

    logic        hclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_len = '0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_err;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    mac_ahb_master #(.BASE_ADDR(BASE)) dut (
        .hclk      (hclk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_err   (res_err),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hwdata    (hwdata),
        .hrdata    (hrdata),
        .hready    (hready),
        .hresp     (hresp)
    );

    always #5 hclk = ~hclk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge hclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Single-precision helpers for the MAC stub (normal numbers and zero only).
    function automatic real sp2real(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:0] == 31'd0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] real2sp(input real v);
        logic        s;
        int          e;
        logic [31:0] mant;
        if (v == 0.0) return 32'd0;
        s = (v < 0.0);
        if (s) v = -v;
        e = 0;
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v < 1.0) begin v = v * 2.0; e--; end
        mant = 32'($rtoi((v - 1.0) * 8388608.0));
        return {s, 8'(e + 127), mant[22:0]};
    endfunction

    // MAC slave stub: A/B/R registers, B write accumulates A*B.
    int          stall_n = 0;
    int          err_idx = -1;
    int          s_cnt_q;
    int          s_wr_idx;
    logic        s_data_q, s_write_q, s_err_q, s_err2_q;
    logic [31:0] s_addr_q;
    logic [31:0] acc_q = '0;
    logic [31:0] a_reg_q = '0;
    logic        s_active;

    assign s_active = (htrans == 2'(TransNonseq)) || s_data_q;
    assign hrdata   = acc_q;

    always_comb begin
        hready = 1'b1;
        hresp  = 1'b0;
        if (s_active && s_cnt_q < stall_n) begin
            hready = 1'b0;
        end else if (s_data_q && s_err_q) begin
            hresp  = 1'b1;
            hready = s_err2_q;
        end
    end

    always @(posedge hclk or negedge rst_n) begin
        if (!rst_n) begin
            s_cnt_q   <= 0;
            s_wr_idx  <= 0;
            s_data_q  <= 1'b0;
            s_write_q <= 1'b0;
            s_err_q   <= 1'b0;
            s_err2_q  <= 1'b0;
            s_addr_q  <= '0;
        end else begin
            s_cnt_q <= (s_active && !hready) ? s_cnt_q + 1 : 0;
            if (cmd_valid && cmd_ready) s_wr_idx <= 0;
            if (htrans == 2'(TransNonseq) && hready) begin
                s_data_q  <= 1'b1;
                s_write_q <= hwrite;
                s_addr_q  <= haddr;
                s_err_q   <= hwrite && (s_wr_idx == err_idx);
                s_err2_q  <= 1'b0;
                if (hwrite) s_wr_idx <= s_wr_idx + 1;
            end else if (s_data_q && hready) begin
                s_data_q <= 1'b0;
                s_err2_q <= 1'b0;
            end else if (s_data_q && s_err_q && hresp) begin
                s_err2_q <= 1'b1;
            end
        end
    end

    always @(posedge hclk) begin
        if (rst_n && s_data_q && hready && s_write_q && !s_err_q) begin
            if (s_addr_q == BASE + MAC_OFS_A) a_reg_q <= hwdata;
            else if (s_addr_q == BASE + MAC_OFS_B)
                acc_q <= real2sp(sp2real(acc_q) + sp2real(a_reg_q) * sp2real(hwdata));
        end
    end

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          wr;
        int          rd;
    } exp_t;

    exp_t sb_q[$];

    // Monitor: bus rules, transfer counting and scoreboard pops on res_valid.
    initial begin
        int          acc_cyc, wr_seen, rd_seen;
        logic        prev_a_stall, prev_d_stall;
        logic [31:0] prev_haddr, prev_hwdata;
        logic [2:0]  prev_ctl;
        exp_t        e;
        acc_cyc = 0; wr_seen = 0; rd_seen = 0;
        prev_a_stall = 1'b0; prev_d_stall = 1'b0;
        prev_haddr = '0; prev_hwdata = '0; prev_ctl = '0;
        forever begin
            @(negedge hclk);
            if (!rst_n) begin
                prev_a_stall = 1'b0;
                prev_d_stall = 1'b0;
            end else begin
                if (prev_a_stall) begin
                    check("haddr_hold", haddr, prev_haddr);
                    check("ctl_hold", {29'd0, hwrite, htrans}, {29'd0, prev_ctl});
                end
                if (prev_d_stall) check("hwdata_hold", hwdata, prev_hwdata);
                if (htrans == 2'(TransNonseq)) check("hsize", {29'd0, hsize}, {29'd0, HSIZE_WORD});
                if (cmd_valid && cmd_ready) begin
                    acc_cyc = cyc;
                    wr_seen = 0;
                    rd_seen = 0;
                end
                if (htrans == 2'(TransNonseq) && hready) begin
                    if (hwrite) wr_seen++;
                    else if (haddr == BASE + MAC_OFS_R) rd_seen++;
                end
                if (res_valid) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_res", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("res_data", res_data, e.data);
                        check("res_err", {31'd0, res_err}, {31'd0, e.err});
                        check("latency", 32'(cyc - acc_cyc + 1), 32'(e.lat));
                        check("writes", 32'(wr_seen), 32'(e.wr));
                        check("reads", 32'(rd_seen), 32'(e.rd));
                    end
                end
                prev_a_stall = (htrans == 2'(TransNonseq)) && !hready;
                prev_d_stall = s_data_q && s_write_q && !hready;
                prev_haddr   = haddr;
                prev_hwdata  = hwdata;
                prev_ctl     = {hwrite, htrans};
            end
        end
    end

    logic [31:0] pa[16];
    logic [31:0] pb[16];

    task automatic run_job(input int len, input int stall, input int eidx, input int hold,
                           input logic [31:0] exp_data, input logic exp_err, input int exp_lat,
                           input int exp_wr, input int exp_rd);
        exp_t e;
        bit   done;
        int   budget;
        stall_n = stall;
        err_idx = eidx;
        e.data = exp_data; e.err = exp_err; e.lat = exp_lat; e.wr = exp_wr; e.rd = exp_rd;
        sb_q.push_back(e);
        cmd_valid = 1'b1;
        cmd_len   = 8'(len);
        budget = 0;
        do begin
            @(negedge hclk);
            budget++;
        end while (!cmd_ready && budget < 100);
        if (!cmd_ready) check("cmd_timeout", 32'd0, 32'd1);
        @(posedge hclk);
        repeat (hold) @(posedge hclk);
        #1 cmd_valid = 1'b0;
        done = 1'b0;
        for (int i = 0; i < len && !done; i++) begin
            op_a = pa[i];
            op_b = pb[i];
            op_valid = 1'b1;
            budget = 0;
            forever begin
                @(negedge hclk);
                budget++;
                if (op_ready) break;
                if (res_valid) begin done = 1'b1; break; end
                if (budget > 500) begin
                    check("op_timeout", 32'd0, 32'd1);
                    done = 1'b1;
                    break;
                end
            end
            if (!done) begin
                @(posedge hclk);
                #1;
            end
        end
        op_valid = 1'b0;
        if (!done) begin
            budget = 0;
            do begin
                @(negedge hclk);
                budget++;
            end while (!res_valid && budget < 2000);
            if (!res_valid) check("res_timeout", 32'd0, 32'd1);
        end
        @(posedge hclk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge hclk);
        #1;
        check("rst_htrans", {30'd0, htrans}, 32'd0);
        check("rst_haddr", haddr, 32'd0);
        check("rst_hwrite", {31'd0, hwrite}, 32'd0);
        check("rst_hwdata", hwdata, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_res_err", {31'd0, res_err}, 32'd0);
        check("rst_op_ready", {31'd0, op_ready}, 32'd0);
        @(negedge hclk) rst_n = 1'b1;
        @(posedge hclk);
        #1 check("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Ten pairs of 0.5*0.5, twice: accumulator is not cleared between jobs.
        for (int i = 0; i < 10; i++) begin pa[i] = 32'h3F00_0000; pb[i] = 32'h3F00_0000; end
        run_job(10, 0, -1, 0, 32'h4020_0000, 1'b0, 54, 20, 1);
        run_job(10, 0, -1, 0, 32'h40A0_0000, 1'b0, 54, 20, 1);

        // Read-only job; cmd_valid left high while busy must not start another job.
        run_job(0, 0, -1, 2, 32'h40A0_0000, 1'b0, 4, 0, 1);

        // Three wait states per phase: 1*2 + 0.5*4 -> 9.0; 14 + 3*10 cycles.
        pa[0] = 32'h3F80_0000; pb[0] = 32'h4000_0000;
        pa[1] = 32'h3F00_0000; pb[1] = 32'h4080_0000;
        run_job(2, 3, -1, 0, 32'h4110_0000, 1'b0, 44, 4, 1);

        // ERROR on the B write of pair 2 of 4: result unchanged, no read.
        for (int i = 0; i < 4; i++) begin pa[i] = 32'h3F80_0000; pb[i] = 32'h3F80_0000; end
        run_job(4, 0, 3, 0, 32'h4110_0000, 1'b1, 13, 4, 0);
        check("err_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Only pair 1 of the aborted job reached the MAC: 9.0 + 1.0.
        run_job(0, 0, -1, 0, 32'h4120_0000, 1'b0, 4, 0, 1);

        // Reset pulse during A_ADDR.
        pa[0] = 32'h3F80_0000; pb[0] = 32'h3F80_0000;
        op_a = pa[0]; op_b = pb[0];
        cmd_valid = 1'b1;
        cmd_len   = 8'd1;
        @(posedge hclk);
        #1 cmd_valid = 1'b0;
        op_valid = 1'b1;
        @(posedge hclk);
        #1 op_valid = 1'b0;
        check("a_addr_nonseq", {30'd0, htrans}, {30'd0, 2'(TransNonseq)});
        check("a_addr_haddr", haddr, BASE + MAC_OFS_A);
        rst_n = 1'b0;
        #1;
        check("async_htrans", {30'd0, htrans}, 32'd0);
        check("async_haddr", haddr, 32'd0);
        check("async_res_data", res_data, 32'd0);
        @(negedge hclk) rst_n = 1'b1;
        @(posedge hclk);
        #1;
        check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("post_rst_op_ready", {31'd0, op_ready}, 32'd0);
        repeat (8) @(posedge hclk);
        #1 check("post_rst_no_result", {31'd0, res_valid}, 32'd0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_ahb_master.md
MAC_AHB_MASTER -- requirements
Module: mac_ahb_master

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, the MAC register base (A at +0x0, B at +0x4, result at +0x8).
REQ-002 SHALL have port hclk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port cmd_valid, input, 1, a job request is present.
REQ-005 SHALL have port cmd_ready, output, 1, high only in IDLE.
REQ-006 SHALL have port cmd_len, input, 8, operand-pair count for the job; 0 means read only.
REQ-007 SHALL have port op_valid, input, 1, an operand pair is present.
REQ-008 SHALL have port op_ready, output, 1, high only in WAIT_OP.
REQ-009 SHALL have port op_a, input, 32, IEEE-754 single operand A.
REQ-010 SHALL have port op_b, input, 32, IEEE-754 single operand B.
REQ-011 SHALL have port res_valid, output, 1, one-cycle result strobe.
REQ-012 SHALL have port res_data, output, 32, read-back accumulator value, held until the next res_valid.
REQ-013 SHALL have port res_err, output, 1, qualified by res_valid; job aborted on an AHB ERROR response.
REQ-014 SHALL have port haddr, output, 32, AHB address.
REQ-015 SHALL have port htrans, output, 2, AHB transfer type; only IDLE (2'b00) and NONSEQ (2'b10) are driven.
REQ-016 SHALL have port hwrite, output, 1, AHB write or read.
REQ-017 SHALL have port hsize, output, 3, constant 3'b010 (word).
REQ-018 SHALL have port hwdata, output, 32, AHB write data.
REQ-019 SHALL have port hrdata, input, 32, AHB read data.
REQ-020 SHALL have port hready, input, 1, AHB transfer-done signal from the slave.
REQ-021 SHALL have port hresp, input, 1, AHB response; 1 means ERROR.

Function
REQ-022 SHALL implement states IDLE, WAIT_OP, A_ADDR, A_DATA, B_ADDR, B_DATA, R_ADDR, R_DATA, DONE.
REQ-023 IDLE: on cmd_valid, latch cmd_len into a remaining-pair counter, then go to WAIT_OP if the count is nonzero, else go to R_ADDR.
REQ-024 WAIT_OP: on op_valid, latch op_a and op_b, then go to A_ADDR; the bus stays IDLE while waiting; there is no timeout.
REQ-025 Each transfer SHALL be a non-overlapped single transfer: one address phase (x_ADDR), then one data phase (x_DATA); htrans = IDLE in every state except x_ADDR.
REQ-026 x_ADDR: drive htrans = NONSEQ with the correct haddr and hwrite (1 for A and B, 0 for R); hold all of them stable until hready is sampled high, then advance to x_DATA.
REQ-027 A_DATA and B_DATA: drive hwdata with the latched A or B value throughout the phase, held until hready is high.
REQ-028 A_DATA completing with hready=1 and hresp=0 SHALL advance to B_ADDR.
REQ-029 B_DATA completing SHALL decrement the counter, then go to WAIT_OP if the counter is nonzero, else go to R_ADDR.
REQ-030 R_DATA: on hready=1 and hresp=0, capture hrdata into res_data and go to DONE.
REQ-031 Any data phase with hready=1 and hresp=1 (second ERROR cycle) SHALL abort the job: set res_err, leave res_data unchanged, go to DONE, and issue no further transfers.
REQ-032 The first ERROR cycle (hready=0, hresp=1) SHALL be treated as a wait state.
REQ-033 DONE: assert res_valid for exactly one cycle, then return to IDLE; res_err is valid in that cycle only.
REQ-034 Best-case latency: cmd accepted with cmd_len=N and op_valid held high -> res_valid after 5N+4 cycles; each hready-low cycle adds one.
REQ-035 cmd_valid in any state other than IDLE SHALL be ignored; it is not queued.
REQ-036 hwdata SHALL be don't-care outside A_DATA and B_DATA.

Reset
REQ-037 Asserting rst_n low SHALL force IDLE, htrans=IDLE, haddr=0, hwrite=0, hwdata=0, res_valid=0, res_data=0, res_err=0, counter=0, cmd_ready=1 (after release), op_ready=0.
REQ-038 Reset mid-transfer SHALL drop htrans to IDLE immediately (asynchronously); the partial job is discarded.

Structure
REQ-039 The shared AHB package SHALL hold the HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ), the HSIZE_WORD constant, and the MAC register offsets (0x0, 0x4, 0x8); the same package is used by cm3_mac and the benches.
REQ-040 There SHALL be a single module with no sub-modules; the state encoding SHALL be a localparam enum local to the module.

Verification
REQ-041 cmd_len=10, ten pairs of A=B=32'h3F000000 (0.5) into cm3_mac -> res_valid with res_data=32'h40200000 (2.5), res_err=0.
REQ-042 A second identical job without reset -> res_data=32'h40A00000 (5.0); confirms the accumulator is not cleared by this block.
REQ-043 cmd_len=0 -> exactly one read NONSEQ at BASE+0x8 and no writes; res_valid after 4 cycles.
REQ-044 Slave stub inserting 3 hready-low cycles in each phase -> haddr, htrans and hwdata stay stable throughout; latency grows by exactly 3 per stalled phase.
REQ-045 ERROR on the B write of pair 2 of 4 -> res_err=1, no transfer to BASE+0x8, return to IDLE.
REQ-046 rst_n pulsed low during A_ADDR -> htrans=IDLE in the same cycle; cmd_ready=1 after release.
